// File: rtl/dice_pkg.sv
// Shared types and defaults for the dice board.
// Used by the ROLL button conditioner and the dice roller.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DOWN,
    REPEAT
  } rb_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1000;
  localparam int DEF_HOLD_CYCLES     = 50000;
  localparam int DEF_REPEAT_CYCLES   = 10000;

  function automatic int rb_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser and restart-on-bounce debouncer.
// flip_o marks the edge on which stable_o toggles.
module sync_debounce
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic RST,
  input  logic btn_i,
  output logic stable_o,
  output logic flip_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] D_TERM = DW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          stable_q;
  logic          stable_d;
  logic [DW-1:0] dcnt_q;
  logic [DW-1:0] dcnt_d;

  always_comb begin
    stable_d = stable_q;
    dcnt_d   = '0;
    flip_o   = 1'b0;
    if (s2_q != stable_q) begin
      if (dcnt_q == D_TERM) begin
        stable_d = ~stable_q;
        flip_o   = 1'b1;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (RST) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      dcnt_q   <= '0;
    end else begin
      s1_q     <= btn_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/roll_button.sv
// ROLL push-button conditioner: debounced level, press pulse,
// long-press detection and auto-repeat pulses.
module roll_button
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic i_clk,
  input  logic RST,
  input  logic BTN_IN,
  output logic ROLL,
  output logic PRESSED,
  output logic HELD
);

  localparam int HW = $clog2(rb_max(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [HW-1:0] H_TERM = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] R_TERM = HW'(REPEAT_CYCLES - 1);

  rb_state_t     state_q;
  rb_state_t     state_d;
  logic [HW-1:0] hcnt_q;
  logic [HW-1:0] hcnt_d;
  logic          roll_q;
  logic          roll_d;
  logic          held_q;
  logic          held_d;
  logic          pressed_q;
  logic          stable;
  logic          flip;
  logic          rise;
  logic          fall;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .i_clk   (i_clk),
    .RST     (RST),
    .btn_i   (BTN_IN),
    .stable_o(stable),
    .flip_o  (flip)
  );

  assign rise = flip & ~stable;
  assign fall = flip & stable;

  always_ff @(posedge i_clk) begin
    if (RST) begin
      state_q   <= IDLE;
      hcnt_q    <= '0;
      roll_q    <= 1'b0;
      held_q    <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      roll_q    <= roll_d;
      held_q    <= held_d;
      pressed_q <= stable ^ flip;
    end
  end

  // Release always takes priority over the hold/repeat terminal count.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = DOWN;
          hcnt_d  = '0;
        end
      end
      DOWN: begin
        if (fall) begin
          state_d = IDLE;
          hcnt_d  = '0;
        end else if (hcnt_q == H_TERM) begin
          if (REPEAT_EN) begin
            state_d = REPEAT;
            hcnt_d  = '0;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (fall) begin
          state_d = IDLE;
          hcnt_d  = '0;
        end else if (hcnt_q == R_TERM) begin
          hcnt_d = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        hcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    roll_d = 1'b0;
    held_d = (state_d == REPEAT);
    unique case (state_q)
      IDLE:    roll_d = rise;
      REPEAT:  roll_d = ~fall & (hcnt_q == R_TERM);
      default: roll_d = 1'b0;
    endcase
  end

  assign ROLL    = roll_q;
  assign PRESSED = pressed_q;
  assign HELD    = held_q;

endmodule

// File: tb/tb_roll_button.sv
// Directed bench for roll_button (DEBOUNCE=4, HOLD=20, REPEAT=8).
// u0 has repeat enabled, u1 has it disabled; both share stimulus.
module tb_roll_button;

  logic i_clk;
  logic RST;
  logic BTN_IN;
  logic roll0, pressed0, held0;
  logic roll1, pressed1, held1;

  int n_cmp;
  int n_bad;

  roll_button #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (8),
    .REPEAT_EN      (1'b1)
  ) u0 (
    .i_clk  (i_clk),
    .RST    (RST),
    .BTN_IN (BTN_IN),
    .ROLL   (roll0),
    .PRESSED(pressed0),
    .HELD   (held0)
  );

  roll_button #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (8),
    .REPEAT_EN      (1'b0)
  ) u1 (
    .i_clk  (i_clk),
    .RST    (RST),
    .BTN_IN (BTN_IN),
    .ROLL   (roll1),
    .PRESSED(pressed1),
    .HELD   (held1)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    RST    = 1'b1;
    BTN_IN = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({roll0, pressed0, held0} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_u0 got=%b want=000", {roll0, pressed0, held0});
    end
    n_cmp++;
    if ({roll1, pressed1, held1} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_u1 got=%b want=000", {roll1, pressed1, held1});
    end
  endtask

  task automatic test_clean_press();
    logic [2:0] exp;
    do_reset();
    for (int i = 1; i <= 25; i++) begin
      BTN_IN = (i <= 10);
      tick();
      exp = {(i == 6), (i >= 6 && i <= 15), 1'b0};
      n_cmp++;
      if ({roll0, pressed0, held0} !== exp) begin
        n_bad++;
        $display("FAIL clean_press edge=%0d got=%b want=%b",
                 i, {roll0, pressed0, held0}, exp);
      end
    end
  endtask

  task automatic test_bouncy_press();
    logic [5:0] pat;
    logic [1:0] exp;
    pat = 6'b101101;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      BTN_IN = (i <= 6) ? pat[6-i] : 1'b1;
      tick();
      exp = {(i == 11), (i >= 11)};
      n_cmp++;
      if ({roll0, pressed0} !== exp) begin
        n_bad++;
        $display("FAIL bouncy_press edge=%0d got=%b want=%b",
                 i, {roll0, pressed0}, exp);
      end
    end
  endtask

  task automatic test_long_press();
    logic [2:0] exp;
    logic       rexp;
    do_reset();
    for (int i = 1; i <= 80; i++) begin
      BTN_IN = (i <= 66);
      tick();
      rexp = (i == 6) || (i >= 34 && i <= 71 && ((i - 26) % 8) == 0);
      exp = {rexp, (i >= 6 && i <= 71), (i >= 26 && i <= 71)};
      n_cmp++;
      if ({roll0, pressed0, held0} !== exp) begin
        n_bad++;
        $display("FAIL long_press edge=%0d got=%b want=%b",
                 i, {roll0, pressed0, held0}, exp);
      end
    end
  endtask

  task automatic test_no_repeat();
    logic [2:0] exp;
    do_reset();
    for (int i = 1; i <= 80; i++) begin
      BTN_IN = (i <= 66);
      tick();
      exp = {(i == 6), (i >= 6 && i <= 71), 1'b0};
      n_cmp++;
      if ({roll1, pressed1, held1} !== exp) begin
        n_bad++;
        $display("FAIL no_repeat edge=%0d got=%b want=%b",
                 i, {roll1, pressed1, held1}, exp);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [2:0] exp;
    do_reset();
    BTN_IN = 1'b1;
    for (int i = 1; i <= 30; i++) tick();
    n_cmp++;
    if (held0 !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_hold_held got=%b want=1", held0);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_cmp++;
    if ({roll0, pressed0, held0} !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_hold_rst got=%b want=000",
               {roll0, pressed0, held0});
    end
    for (int j = 1; j <= 10; j++) begin
      tick();
      exp = {(j == 6), (j >= 6), 1'b0};
      n_cmp++;
      if ({roll0, pressed0, held0} !== exp) begin
        n_bad++;
        $display("FAIL mid_hold_repress edge=%0d got=%b want=%b",
                 j, {roll0, pressed0, held0}, exp);
      end
    end
  endtask

  task automatic test_release_terminal();
    logic [2:0] exp;
    do_reset();
    for (int i = 1; i <= 45; i++) begin
      BTN_IN = (i <= 28);
      tick();
      exp = {(i == 6), (i >= 6 && i <= 33), (i >= 26 && i <= 33)};
      n_cmp++;
      if ({roll0, pressed0, held0} !== exp) begin
        n_bad++;
        $display("FAIL rel_terminal edge=%0d got=%b want=%b",
                 i, {roll0, pressed0, held0}, exp);
      end
    end
    for (int j = 1; j <= 8; j++) begin
      BTN_IN = 1'b1;
      tick();
      exp = {(j == 6), (j >= 6), 1'b0};
      n_cmp++;
      if ({roll0, pressed0, held0} !== exp) begin
        n_bad++;
        $display("FAIL rel_terminal_repress edge=%0d got=%b want=%b",
                 j, {roll0, pressed0, held0}, exp);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    RST    = 1'b1;
    BTN_IN = 1'b0;
    test_reset();
    test_clean_press();
    test_bouncy_press();
    test_long_press();
    test_no_repeat();
    test_reset_mid_hold();
    test_release_terminal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
